// File: rtl/expr_eval_pkg.sv
// Shared definitions for the single-digit expression evaluator and its character classifier.
package expr_eval_pkg;

  typedef enum logic [1:0] {
    EXP_DIGIT = 2'd0,
    EXP_OP    = 2'd1,
    DRAIN     = 2'd2
  } state_t;

  localparam logic [7:0] CH_PLUS = 8'h2B;
  localparam logic [7:0] CH_MUL  = 8'h2A;
  localparam logic [7:0] CH_EQ   = 8'h3D;
  localparam logic [7:0] CH_0    = 8'h30;
  localparam logic [7:0] CH_9    = 8'h39;

  function automatic logic is_digit(input logic [7:0] c);
    return (c >= CH_0) && (c <= CH_9);
  endfunction

endpackage

// File: rtl/expr_char_class.sv
// Combinational ASCII classifier: digit / '+' / '*' / '=' / illegal, plus the digit value.
module expr_char_class
  import expr_eval_pkg::*;
(
  input  logic [7:0] ch,
  output logic       digit,
  output logic       plus,
  output logic       mul,
  output logic       eq,
  output logic       illegal,
  output logic [3:0] digit_val
);

  always_comb begin
    digit   = is_digit(ch);
    plus    = (ch == CH_PLUS);
    mul     = (ch == CH_MUL);
    eq      = (ch == CH_EQ);
    illegal = !(digit || plus || mul || eq);
    // '0'..'9' are 0x30..0x39, so the low nibble is the value
    digit_val = digit ? ch[3:0] : 4'd0;
  end

endmodule

// File: rtl/expr_eval.sv
// Streaming evaluator for "digit (op digit)* =" with '*' binding tighter than '+'.
// A pending product lives in term; completed terms are folded into sum on '+'.
//   state     | meaning
//   EXP_DIGIT | expecting a digit (start of expression or after an operator)
//   EXP_OP    | expecting '+', '*' or '='
//   DRAIN     | malformed expression, discard characters until '='
module expr_eval
  import expr_eval_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         in_valid,
  input  logic [7:0]   in,
  output logic         done,
  output logic [W-1:0] result,
  output logic         err,
  output logic         ovf,
  output logic         busy
);

  state_t         state, state_n;
  logic [W-1:0]   sum, sum_n, term, term_n, result_n;
  logic           mul_pend, mul_pend_n, ovf_acc, ovf_acc_n;
  logic           done_n, err_n, ovf_n, busy_n;
  logic           emit_ok, emit_err;
  logic [W+3:0]   prod;
  logic [W:0]     add;

  logic           c_digit, c_plus, c_mul, c_eq, c_illegal;
  logic [3:0]     digit_val;

  expr_char_class u_class (
    .ch        (in),
    .digit     (c_digit),
    .plus      (c_plus),
    .mul       (c_mul),
    .eq        (c_eq),
    .illegal   (c_illegal),
    .digit_val (digit_val)
  );

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state    <= EXP_DIGIT;
      sum      <= '0;
      term     <= '0;
      mul_pend <= 1'b0;
      ovf_acc  <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      err      <= 1'b0;
      ovf      <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_n;
      sum      <= sum_n;
      term     <= term_n;
      mul_pend <= mul_pend_n;
      ovf_acc  <= ovf_acc_n;
      done     <= done_n;
      result   <= result_n;
      err      <= err_n;
      ovf      <= ovf_n;
      busy     <= busy_n;
    end
  end

  always_comb begin
    state_n    = state;
    sum_n      = sum;
    term_n     = term;
    mul_pend_n = mul_pend;
    ovf_acc_n  = ovf_acc;
    busy_n     = busy;
    done_n     = 1'b0;
    result_n   = result;
    err_n      = err;
    ovf_n      = ovf;
    emit_ok    = 1'b0;
    emit_err   = 1'b0;
    prod       = (W+4)'(term) * (W+4)'(digit_val);
    add        = (W+1)'(sum) + (W+1)'(term);

    if (in_valid) begin
      case (state)
        EXP_DIGIT: begin
          if (c_digit) begin
            term_n     = mul_pend ? prod[W-1:0] : W'(digit_val);
            ovf_acc_n  = ovf_acc | (mul_pend & (|prod[W+3:W]));
            mul_pend_n = 1'b0;
            busy_n     = 1'b1;
            state_n    = EXP_OP;
          end else if (c_eq) begin
            emit_err = 1'b1;
          end else begin
            busy_n  = 1'b1;
            state_n = DRAIN;
          end
        end
        EXP_OP: begin
          if (c_plus) begin
            sum_n     = add[W-1:0];
            ovf_acc_n = ovf_acc | add[W];
            state_n   = EXP_DIGIT;
          end else if (c_mul) begin
            mul_pend_n = 1'b1;
            state_n    = EXP_DIGIT;
          end else if (c_eq) begin
            emit_ok = 1'b1;
          end else begin
            state_n = DRAIN;
          end
        end
        DRAIN: begin
          if (c_eq) emit_err = 1'b1;
        end
        default: state_n = DRAIN;
      endcase
    end

    if (emit_ok || emit_err) begin
      done_n     = 1'b1;
      result_n   = emit_ok ? add[W-1:0] : '0;
      err_n      = emit_err;
      ovf_n      = emit_ok & (ovf_acc | add[W]);
      sum_n      = '0;
      term_n     = '0;
      mul_pend_n = 1'b0;
      ovf_acc_n  = 1'b0;
      busy_n     = 1'b0;
      state_n    = EXP_DIGIT;
    end
  end

endmodule

// File: tb/tb_expr_eval.sv
// Scoreboard bench for expr_eval: one W=16 and one W=8 instance driven by the same character stream.
module tb_expr_eval;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_ch = 8'h00;

  logic        done_a, err_a, ovf_a, busy_a;
  logic [15:0] result_a;
  logic        done_b, err_b, ovf_b, busy_b;
  logic [7:0]  result_b;

  typedef struct {
    logic [15:0] r;
    logic        e;
    logic        o;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int eq_cyc = -100;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  expr_eval #(.W(16)) dut_a (
    .clk(clk), .clr(clr), .in_valid(in_valid), .in(in_ch),
    .done(done_a), .result(result_a), .err(err_a), .ovf(ovf_a), .busy(busy_a)
  );

  expr_eval #(.W(8)) dut_b (
    .clk(clk), .clr(clr), .in_valid(in_valid), .in(in_ch),
    .done(done_b), .result(result_b), .err(err_b), .ovf(ovf_b), .busy(busy_b)
  );

  // Result checkers: every done pops one expectation and must follow '=' by exactly one edge.
  always @(negedge clk) begin
    exp_t x;
    if (!clr && done_a) begin
      checks++;
      if (q_a.size() == 0) begin
        errors++;
        $display("FAIL w16_unexpected_done result=%0d err=%0b ovf=%0b", result_a, err_a, ovf_a);
      end else begin
        x = q_a.pop_front();
        if ({result_a, err_a, ovf_a} !== {x.r, x.e, x.o}) begin
          errors++;
          $display("FAIL w16_result got r=%0d e=%0b o=%0b want r=%0d e=%0b o=%0b",
                   result_a, err_a, ovf_a, x.r, x.e, x.o);
        end
      end
      checks++;
      if (cyc != eq_cyc) begin
        errors++;
        $display("FAIL w16_latency done at cycle %0d want %0d", cyc, eq_cyc);
      end
    end
  end

  always @(negedge clk) begin
    exp_t x;
    if (!clr && done_b) begin
      checks++;
      if (q_b.size() == 0) begin
        errors++;
        $display("FAIL w8_unexpected_done result=%0d err=%0b ovf=%0b", result_b, err_b, ovf_b);
      end else begin
        x = q_b.pop_front();
        if ({8'h00, result_b, err_b, ovf_b} !== {x.r, x.e, x.o}) begin
          errors++;
          $display("FAIL w8_result got r=%0d e=%0b o=%0b want r=%0d e=%0b o=%0b",
                   result_b, err_b, ovf_b, x.r, x.e, x.o);
        end
      end
    end
  end

  task automatic push_exp(input int r16, input bit o16, input int r8, input bit o8, input bit e);
    exp_t x;
    x.r = 16'(r16); x.e = e; x.o = o16;
    q_a.push_back(x);
    x.r = 16'(r8);  x.e = e; x.o = o8;
    q_b.push_back(x);
  endtask

  // Called at posedge+1; consumes one character on the next edge.
  task automatic send(input byte c);
    in_valid = 1'b1;
    in_ch    = c;
    @(posedge clk);
    #1;
    if (c == "=") eq_cyc = cyc;
    in_valid = 1'b0;
  endtask

  task automatic send_str(input string s, input int gap);
    for (int i = 0; i < s.len(); i++) begin
      send(s[i]);
      repeat (gap) begin @(posedge clk); #1; end
    end
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((q_a.size() != 0 || q_b.size() != 0) && n < 6) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (q_a.size() != 0 || q_b.size() != 0) begin
      errors++;
      $display("FAIL %s_missing_done pending w16=%0d w8=%0d want 0", name, q_a.size(), q_b.size());
      q_a.delete(); q_b.delete();
    end
  endtask

  task automatic check_idle(input string name);
    checks++;
    if ({done_a, result_a, err_a, ovf_a, busy_a, done_b, result_b, err_b, ovf_b, busy_b} !== '0) begin
      errors++;
      $display("FAIL %s_outputs_zero got a:d=%0b r=%0d e=%0b o=%0b b=%0b b:d=%0b r=%0d e=%0b o=%0b b=%0b want all 0",
               name, done_a, result_a, err_a, ovf_a, busy_a, done_b, result_b, err_b, ovf_b, busy_b);
    end
  endtask

  task automatic check_busy(input string name, input bit want);
    checks++;
    if (busy_a !== want || busy_b !== want) begin
      errors++;
      $display("FAIL %s_busy got %0b/%0b want %0b", name, busy_a, busy_b, want);
    end
  endtask

  task automatic test_reset();
    #3;
    check_idle("reset");
    @(posedge clk); #1;
    clr = 1'b0;
    @(posedge clk); #1;
    check_idle("post_reset");
  endtask

  task automatic test_precedence();
    send("1");
    check_busy("prec_first_char", 1'b1);
    push_exp(7, 0, 7, 0, 0);
    send_str("+2*3=", 0);
    drain("prec");
    check_busy("prec_after", 1'b0);
  endtask

  task automatic test_overflow();
    push_exp(729, 0, 217, 1, 0);
    send_str("9*9*9=", 0);
    drain("ovf_mul");
    push_exp(18, 0, 18, 0, 0);
    send_str("9+9=", 0);
    drain("ovf_clear");
    // 200+100 carries out of 8 bits only
    push_exp(300, 0, 44, 1, 0);
    send_str("5*5*8+4*5*5=", 0);
    drain("ovf_add");
  endtask

  task automatic test_malformed();
    string cases[4] = '{"12+3=", "1+=", "=", "1a2="};
    foreach (cases[i]) begin
      push_exp(0, 0, 0, 0, 1);
      send_str(cases[i], 0);
      drain("malformed");
      check_busy("malformed_after", 1'b0);
    end
  endtask

  task automatic test_gaps();
    push_exp(20, 0, 20, 0, 0);
    send_str("4*5=", 3);
    drain("gaps");
  endtask

  task automatic test_back_to_back();
    push_exp(1, 0, 1, 0, 0);
    push_exp(2, 0, 2, 0, 0);
    send("1");
    send("=");
    checks++;
    if (done_a !== 1'b1) begin
      errors++;
      $display("FAIL b2b_first_done got %0b want 1", done_a);
    end
    send("2");
    send("=");
    drain("b2b");
  endtask

  task automatic test_reset_mid();
    send("7");
    send("*");
    check_busy("mid_before_clr", 1'b1);
    #2;
    clr = 1'b1;
    #1;
    check_idle("mid_clr");
    @(posedge clk); #1;
    clr = 1'b0;
    push_exp(3, 0, 3, 0, 0);
    send_str("3=", 0);
    drain("after_clr");
  endtask

  initial begin
    test_reset();
    test_precedence();
    test_overflow();
    test_malformed();
    test_gaps();
    test_back_to_back();
    test_reset_mid();
    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/expr_eval.md
Name: expr_eval

Overview:
- Downstream consumer of the per-clock character stream checked by the expression-syntax recogniser.
- Evaluates single-digit arithmetic expressions of the form digit (op digit)*, where op is '+' or '*', terminated by '='.
- '*' binds tighter than '+'.
- On each '=' it emits one result strobe carrying the value, an error flag and an overflow flag, then re-arms for the next expression.

Parameters:
- W, 16, width of result and of internal sum/term accumulators (W >= 4).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- clr  input  1  asynchronous active-high reset.
- in_valid  input  1  in carries a character this cycle.
- in  input  8  ASCII character: '0'-'9', '+', '*', '=', anything else is illegal.
- done  output  1  one-cycle strobe; result/err/ovf valid while high and held until next done.
- result  output  W  expression value modulo 2^W; 0 when err=1.
- err  output  1  expression was malformed.
- ovf  output  1  some intermediate or final value exceeded 2^W-1 (truncated); 0 when err=1.
- busy  output  1  at least one character of the current expression has been accepted and '=' not yet seen.

Behaviour:
- Clock and reset: one clock, clk. Reset clr is asynchronous, active-high.
- While clr is high, and immediately on its assertion:
  - state=EXP_DIGIT; sum=0, term=0, mul_pend=0, ovf_acc=0.
  - done=0, result=0, err=0, ovf=0, busy=0.
  - clr mid-expression discards the partial expression; no done is produced for it.
- Character acceptance: a character is consumed only on a rising edge with in_valid=1. in_valid=0 holds all state; done still drops after its single cycle. No backpressure: every valid character is accepted.
- State EXP_DIGIT (expecting a digit):
  - digit d: term <= mul_pend ? trunc(term*d) : d; mul_pend<=0; ovf_acc |= (full product > 2^W-1); busy<=1; go to EXP_OP.
  - '=' (empty expression or trailing op): emit error; go to EXP_DIGIT.
  - '+', '*', illegal: busy<=1; go to DRAIN.
- State EXP_OP (expecting an operator or terminator):
  - '+': sum <= trunc(sum+term); ovf_acc |= carry; go to EXP_DIGIT.
  - '*': mul_pend<=1; go to EXP_DIGIT.
  - '=': emit success with value trunc(sum+term), ovf = ovf_acc | carry; go to EXP_DIGIT.
  - digit (multi-digit number) or illegal: go to DRAIN.
- State DRAIN (error latched): ignore all characters except '='. On '=': emit error; go to EXP_DIGIT.
- Emit actions are registered on the same edge that samples '=', so done is high for exactly the following cycle:
  - Emit success: done<=1, result<=value, err<=0, ovf<=flag.
  - Emit error: done<=1, result<=0, err<=1, ovf<=0.
  - Every emit also clears sum, term, mul_pend, ovf_acc and busy.
- Back-to-back expressions: a digit in the cycle directly after '=' starts the next expression with no bubble. "1=2=" yields done on two consecutive cycles.
- Arithmetic:
  - Digits are converted as in-'0', a 4-bit value 0-9.
  - The product is computed at W+4 bits and truncated to W; ovf_acc is set if the upper 4 bits are non-zero.
  - Sums are computed at W+1 bits; the carry sets ovf.
- Latency: result available 1 cycle after '=' is sampled, independent of expression length.
- busy: 1 from the first accepted character until the edge that samples '='.

Decomposition:
- Shared package:
  - state encoding EXP_DIGIT=2'd0, EXP_OP=2'd1, DRAIN=2'd2;
  - character constants CH_PLUS, CH_MUL, CH_EQ, CH_0, CH_9;
  - an is_digit helper.
- One sub-module is natural: expr_char_class. It is combinational, maps in to {is_digit, is_plus, is_mul, is_eq, is_illegal, digit_val[3:0]}, and the recogniser can reuse it.
- FSM, accumulators and output registers stay in expr_eval.

Test Plan:
- Precedence: W=16, "1+2*3=" streamed one char per cycle -> done 1 cycle after '=', result=7, err=0, ovf=0, busy=0 afterwards.
- Overflow: W=8, "9*9*9=" -> result=217 (729 mod 256), ovf=1, err=0. Then "9+9=" -> result=18, ovf=0.
- Malformed input, each giving done with err=1, result=0, ovf=0:
  - "12+3=" (multi-digit number);
  - "1+=" (trailing operator);
  - "=" (empty expression);
  - "1a2=" (illegal character, DRAIN ignores '2').
- Gaps and back-to-back: "4*5=" with in_valid low for 3 cycles between every char -> result=20. Then "1=2=" with no gaps -> done on two consecutive cycles, results 1 then 2.
- Reset mid-expression: assert clr asynchronously mid-cycle after "7*" -> all outputs 0 immediately. Then "3=" -> result=3, not 21.
